// File: rtl/video_pll_pkg.sv
// Shared types and the per-mode divider table for the video rPLL supervisor.
// Divider fields hold the rPLL dynamic encodings, not the raw divide ratios.
package video_pll_pkg;

  typedef enum logic [1:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  typedef struct packed {
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } pll_div_t;

  localparam int TABLE_DEPTH = 4;

  // IDSEL/FBDSEL carry 64 minus the divide ratio.
  function automatic logic [5:0] enc_div(input int n);
    return 6'(64 - n);
  endfunction

  function automatic logic [5:0] enc_odiv(input int n);
    case (n)
      4:       return 6'b111110;
      8:       return 6'b111100;
      16:      return 6'b111000;
      32:      return 6'b110000;
      48:      return 6'b101000;
      64:      return 6'b100000;
      80:      return 6'b011000;
      96:      return 6'b010000;
      112:     return 6'b001000;
      128:     return 6'b000000;
      default: return 6'b111111;
    endcase
  endfunction

  // 27 MHz reference: 720p60, 1080p60, 480p, 640x480@60.
  localparam pll_div_t MODE_TABLE [TABLE_DEPTH] = '{
    '{idsel: enc_div(4),  fbdsel: enc_div(11), odsel: enc_odiv(8)},
    '{idsel: enc_div(2),  fbdsel: enc_div(11), odsel: enc_odiv(4)},
    '{idsel: enc_div(1),  fbdsel: enc_div(1),  odsel: enc_odiv(32)},
    '{idsel: enc_div(15), fbdsel: enc_div(14), odsel: enc_odiv(32)}
  };

  function automatic pll_div_t mode_lookup(input logic [31:0] m);
    pll_div_t r;
    r = MODE_TABLE[0];
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      if (m == 32'(i)) r = MODE_TABLE[i];
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/video_pll_lock_sync.sv
// Two-flop synchroniser bringing the raw rPLL LOCK into the clkin domain.
module video_pll_lock_sync (
  input  logic clkin,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // NOTE: non-blocking assignments make both flops sample on the same edge, giving a true two-stage chain.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/video_pll_ctrl.sv
// Video rPLL mode-switch supervisor: programs dynamic dividers, sequences PLL
// reset, and qualifies LOCK with a stability filter, timeout and bounded retries.
module video_pll_ctrl
  import video_pll_pkg::*;
#(
  parameter int NUM_MODES        = 4,
  parameter int MODE_W           = 2,
  parameter int DEFAULT_MODE     = 0,
  parameter int RESET_HOLD_CYC   = 16,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              mode_req_ready,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        idsel,
  output logic [5:0]        fbdsel,
  output logic [5:0]        odsel,
  output logic [MODE_W-1:0] cur_mode,
  output logic              locked,
  output logic              video_rst,
  output logic              err,
  output logic              bad_mode
);

  localparam int CNT_MAX = max3(RESET_HOLD_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_stable;
  logic [RTY_W-1:0]   r_retry;
  logic               r_pll_reset;
  logic               r_locked;
  logic               r_video_rst;
  logic               r_err;
  logic               r_bad_mode;
  logic               r_ready;
  logic [MODE_W-1:0]  r_mode;
  pll_div_t           r_div;

  logic               w_lock_s;
  logic               w_accept;
  logic               w_req_ok;
  pll_div_t           w_req_div;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  video_pll_lock_sync u_lock_sync (
    .clkin   (clkin),
    .reset   (reset),
    .i_async (pll_lock),
    .o_sync  (w_lock_s)
  );

  assign w_accept  = mode_req_valid & r_ready;
  assign w_req_ok  = (32'(mode_req) < 32'(NUM_MODES));
  assign w_req_div = mode_lookup(32'(mode_req));

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RST_PLL;
      r_cnt       <= '0;
      r_stable    <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_locked    <= 1'b0;
      r_video_rst <= 1'b1;
      r_err       <= 1'b0;
      r_bad_mode  <= 1'b0;
      r_ready     <= 1'b0;
      r_mode      <= MODE_W'(DEFAULT_MODE);
      r_div       <= mode_lookup(32'(DEFAULT_MODE));
    end else begin
      r_bad_mode <= w_accept & ~w_req_ok;
      // A valid accepted request outranks whatever the FSM would do this cycle.
      if (w_accept && w_req_ok) begin
        r_mode      <= mode_req;
        r_div       <= w_req_div;
        r_err       <= 1'b0;
        r_retry     <= '0;
        r_state     <= ST_RST_PLL;
        r_cnt       <= '0;
        r_stable    <= '0;
        r_pll_reset <= 1'b1;
        r_locked    <= 1'b0;
        r_video_rst <= 1'b1;
        r_ready     <= 1'b0;
      end else begin
        case (r_state)
          ST_RST_PLL: begin
            if (r_cnt == CNT_W'(RESET_HOLD_CYC - 1)) begin
              r_state     <= ST_WAIT_LOCK;
              r_cnt       <= '0;
              r_stable    <= '0;
              r_pll_reset <= 1'b0;
            end else begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
          ST_WAIT_LOCK: begin
            if (w_lock_s && r_stable == CNT_W'(LOCK_STABLE_CYC - 1)) begin
              r_state     <= ST_LOCKED;
              r_retry     <= '0;
              r_locked    <= 1'b1;
              r_video_rst <= 1'b0;
              r_ready     <= 1'b1;
            end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
              r_cnt       <= '0;
              r_stable    <= '0;
              r_pll_reset <= 1'b1;
              if (r_retry == RTY_W'(MAX_RETRY)) begin
                r_state <= ST_FAIL;
                r_err   <= 1'b1;
                r_ready <= 1'b1;
              end else begin
                r_state <= ST_RST_PLL;
                r_retry <= r_retry + 1'b1;
              end
            end else begin
              r_cnt    <= sat_inc(r_cnt);
              r_stable <= w_lock_s ? sat_inc(r_stable) : '0;
            end
          end
          ST_LOCKED: begin
            if (!w_lock_s) begin
              r_state     <= ST_RST_PLL;
              r_cnt       <= '0;
              r_stable    <= '0;
              r_retry     <= '0;
              r_pll_reset <= 1'b1;
              r_locked    <= 1'b0;
              r_video_rst <= 1'b1;
              r_ready     <= 1'b0;
            end
          end
          ST_FAIL: begin
            r_pll_reset <= 1'b1;
            r_err       <= 1'b1;
            r_ready     <= 1'b1;
          end
          default: r_state <= ST_RST_PLL;
        endcase
      end
    end
  end

  assign mode_req_ready = r_ready;
  assign pll_reset      = r_pll_reset;
  assign idsel          = r_div.idsel;
  assign fbdsel         = r_div.fbdsel;
  assign odsel          = r_div.odsel;
  assign cur_mode       = r_mode;
  assign locked         = r_locked;
  assign video_rst      = r_video_rst;
  assign err            = r_err;
  assign bad_mode       = r_bad_mode;

endmodule

// File: tb/tb_video_pll_ctrl.sv
// Scoreboard bench for video_pll_ctrl: stimulus queues cycle-stamped expected
// output snapshots, a negedge monitor pops and compares them.
module tb_video_pll_ctrl;

  localparam int MODE_W = 3;

  logic              clkin = 1'b0;
  logic              reset = 1'b1;
  logic [MODE_W-1:0] mode_req = '0;
  logic              mode_req_valid = 1'b0;
  logic              pll_lock = 1'b1;
  logic              mode_req_ready;
  logic              pll_reset;
  logic [5:0]        idsel, fbdsel, odsel;
  logic [MODE_W-1:0] cur_mode;
  logic              locked, video_rst, err, bad_mode;

  // Hand-encoded dividers: 64-IDIV, 64-FBDIV, ODIV code.
  localparam logic [5:0] EXP_ID [4] = '{6'd60, 6'd62, 6'd63, 6'd49};
  localparam logic [5:0] EXP_FB [4] = '{6'd53, 6'd53, 6'd63, 6'd50};
  localparam logic [5:0] EXP_OD [4] = '{6'd60, 6'd62, 6'd48, 6'd48};

  typedef struct packed {
    int   cyc;
    logic pr;
    logic lk;
    logic er;
    logic rd;
    logic bm;
    int   md;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  video_pll_ctrl #(
    .NUM_MODES        (4),
    .MODE_W           (MODE_W),
    .DEFAULT_MODE     (0),
    .RESET_HOLD_CYC   (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (64),
    .MAX_RETRY        (2)
  ) dut (
    .clkin          (clkin),
    .reset          (reset),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .pll_lock       (pll_lock),
    .pll_reset      (pll_reset),
    .idsel          (idsel),
    .fbdsel         (fbdsel),
    .odsel          (odsel),
    .cur_mode       (cur_mode),
    .locked         (locked),
    .video_rst      (video_rst),
    .err            (err),
    .bad_mode       (bad_mode)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int c, input logic pr, input logic lk,
                           input logic er, input logic rd, input logic bm, input int md);
    exp_t e;
    e.cyc = c; e.pr = pr; e.lk = lk; e.er = er; e.rd = rd; e.bm = bm; e.md = md;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare(input string tag, input exp_t e);
    check($sformatf("%s pll_reset", tag), pll_reset, e.pr);
    check($sformatf("%s locked", tag), locked, e.lk);
    check($sformatf("%s video_rst", tag), video_rst, !e.lk);
    check($sformatf("%s err", tag), err, e.er);
    check($sformatf("%s ready", tag), mode_req_ready, e.rd);
    check($sformatf("%s bad_mode", tag), bad_mode, e.bm);
    check($sformatf("%s cur_mode", tag), cur_mode, e.md);
    check($sformatf("%s idsel", tag), idsel, EXP_ID[e.md]);
    check($sformatf("%s fbdsel", tag), fbdsel, EXP_FB[e.md]);
    check($sformatf("%s odsel", tag), odsel, EXP_OD[e.md]);
  endtask

  always @(negedge clkin) begin : monitor
    exp_t  e;
    string tag;
    if (!reset) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        if (e.cyc < cyc) check($sformatf("%s cycle", tag), cyc, e.cyc);
        else             compare(tag, e);
      end
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clkin);
  endtask

  task automatic request(input int m);
    mode_req       = MODE_W'(m);
    mode_req_valid = 1'b1;
    @(negedge clkin);
    mode_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  initial begin
    int a, c, e;

    // Power-up with lock tied high.
    repeat (3) @(posedge clkin);
    #2 reset = 1'b0;
    expect_at("pwr c0",  0,  1, 0, 0, 0, 0, 0);
    expect_at("pwr c3",  3,  1, 0, 0, 0, 0, 0);
    expect_at("pwr c4",  4,  0, 0, 0, 0, 0, 0);
    expect_at("pwr c11", 11, 0, 0, 0, 0, 0, 0);
    expect_at("pwr c12", 12, 0, 1, 0, 1, 0, 0);
    @(negedge clkin);
    to_cyc(14);

    // Mode change to 2.
    a = cyc + 1;
    expect_at("m2 accept", a,      1, 0, 0, 0, 0, 2);
    expect_at("m2 hold3",  a + 3,  1, 0, 0, 0, 0, 2);
    expect_at("m2 wait",   a + 4,  0, 0, 0, 0, 0, 2);
    expect_at("m2 pre",    a + 11, 0, 0, 0, 0, 0, 2);
    expect_at("m2 lock",   a + 12, 0, 1, 0, 1, 0, 2);
    request(2);
    to_cyc(a + 14);

    // Mode change to 1 with a one-cycle lock glitch at stable count 5.
    a = cyc + 1;
    expect_at("gl accept", a,      1, 0, 0, 0, 0, 1);
    expect_at("gl wait",   a + 4,  0, 0, 0, 0, 0, 1);
    expect_at("gl c12",    a + 12, 0, 0, 0, 0, 0, 1);
    expect_at("gl pre",    a + 17, 0, 0, 0, 0, 0, 1);
    expect_at("gl lock",   a + 18, 0, 1, 0, 1, 0, 1);
    request(1);
    to_cyc(a + 7);
    pll_lock = 1'b0;
    to_cyc(a + 8);
    pll_lock = 1'b1;
    to_cyc(a + 20);

    // Lock loss while LOCKED.
    c = cyc;
    expect_at("loss c2",  c + 2,  0, 1, 0, 1, 0, 1);
    expect_at("loss c3",  c + 3,  1, 0, 0, 0, 0, 1);
    expect_at("loss pre", c + 14, 0, 0, 0, 0, 0, 1);
    expect_at("loss rel", c + 15, 0, 1, 0, 1, 0, 1);
    pll_lock = 1'b0;
    to_cyc(c + 3);
    pll_lock = 1'b1;
    to_cyc(c + 17);

    // Out-of-range requests 5 and 4.
    c = cyc;
    expect_at("bad5",      c + 1, 0, 1, 0, 1, 1, 1);
    expect_at("bad5 end",  c + 2, 0, 1, 0, 1, 0, 1);
    expect_at("bad4",      c + 3, 0, 1, 0, 1, 1, 1);
    expect_at("bad4 end",  c + 4, 0, 1, 0, 1, 0, 1);
    request(5);
    to_cyc(c + 2);
    request(4);
    to_cyc(c + 6);

    // Lock held low: retries, FAIL, then recovery by request.
    c = cyc;
    e = c + 3;
    expect_at("to entry",  e,       1, 0, 0, 0, 0, 1);
    expect_at("to wait0",  e + 4,   0, 0, 0, 0, 0, 1);
    expect_at("to ignore", e + 22,  0, 0, 0, 0, 0, 1);
    expect_at("to w0end",  e + 67,  0, 0, 0, 0, 0, 1);
    expect_at("to rst1",   e + 68,  1, 0, 0, 0, 0, 1);
    expect_at("to rst1e",  e + 71,  1, 0, 0, 0, 0, 1);
    expect_at("to wait1",  e + 72,  0, 0, 0, 0, 0, 1);
    expect_at("to rst2",   e + 136, 1, 0, 0, 0, 0, 1);
    expect_at("to wait2",  e + 140, 0, 0, 0, 0, 0, 1);
    expect_at("to w2end",  e + 203, 0, 0, 0, 0, 0, 1);
    expect_at("to fail",   e + 204, 1, 0, 1, 1, 0, 1);
    expect_at("to fhold",  e + 210, 1, 0, 1, 1, 0, 1);
    pll_lock = 1'b0;
    to_cyc(e + 20);
    request(3);
    to_cyc(e + 210);
    a = cyc + 1;
    expect_at("rec accept", a,      1, 0, 0, 0, 0, 1);
    expect_at("rec wait",   a + 4,  0, 0, 0, 0, 0, 1);
    expect_at("rec pre",    a + 11, 0, 0, 0, 0, 0, 1);
    expect_at("rec lock",   a + 12, 0, 1, 0, 1, 0, 1);
    pll_lock = 1'b1;
    request(1);
    to_cyc(a + 14);

    // Accept and lock loss on the same edge: accept wins.
    c = cyc;
    expect_at("sim accept", c + 3,  1, 0, 0, 0, 0, 3);
    expect_at("sim pre",    c + 14, 0, 0, 0, 0, 0, 3);
    expect_at("sim lock",   c + 15, 0, 1, 0, 1, 0, 3);
    pll_lock = 1'b0;
    to_cyc(c + 2);
    request(3);
    pll_lock = 1'b1;
    to_cyc(c + 17);

    // Asynchronous reset in the middle of a mode change.
    c = cyc;
    expect_at("ar accept", c + 1, 1, 0, 0, 0, 0, 2);
    request(2);
    to_cyc(c + 3);
    #2 reset = 1'b1;
    #1;
    check("arst pll_reset", pll_reset, 1'b1);
    check("arst locked", locked, 1'b0);
    check("arst video_rst", video_rst, 1'b1);
    check("arst err", err, 1'b0);
    check("arst bad_mode", bad_mode, 1'b0);
    check("arst ready", mode_req_ready, 1'b0);
    check("arst cur_mode", cur_mode, 0);
    check("arst idsel", idsel, EXP_ID[0]);
    check("arst odsel", odsel, EXP_OD[0]);
    repeat (2) @(posedge clkin);
    #2 reset = 1'b0;
    expect_at("ar2 c0",  0,  1, 0, 0, 0, 0, 0);
    expect_at("ar2 c4",  4,  0, 0, 0, 0, 0, 0);
    expect_at("ar2 c12", 12, 0, 1, 0, 1, 0, 0);
    @(negedge clkin);
    to_cyc(14);

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clkin);
    if (exp_q.size() > 0) check("scoreboard drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
